// File: rtl/axis_pkg.sv
// Shared types and widths for the AXI4-Stream pixel sink.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axis_pkg;

    localparam int PIX_W  = 32;  // pixel data width
    localparam int FCNT_W = 16;  // completed-frame counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } sink_state_t;

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker: x counts 0..WIDTH-1 per line, y counts lines, wraps to (0,0).
// Latency: position updates at the edge that samples advance/restart; at_last is combinational.
// Backpressure: none; caller qualifies advance with its own handshake.
//
// Ports: aclk/aresetn clock and async active-low reset; advance steps one pixel;
// restart forces (0,0) and wins over advance; x/y next expected pixel; at_last true at final pixel.
module raster_counter #(
    parameter int WIDTH = 20,
    parameter int HEIGHT = 20,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          advance,
    input  logic          restart,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          at_last
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (restart) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign at_last = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/axis_frame_sink.sv
// AXI4-Stream frame consumer: tracks raster position, checks tlast placement, counts frames.
// Latency: all outputs registered; frame_done/frame_sum/frame_count visible the cycle after the final beat.
// Backpressure: tready high only in RECV; one dead cycle after each frame, low while idle.
//
// Ports: aclk/aresetn; s_axis_* slave stream; enable gates new frames; clear_errors clears sticky flags;
// pix_x/pix_y next expected pixel; frame_done pulse; frame_count; frame_sum; err_early_last/err_missing_last.
// Build option: define AXIS_FRAME_SINK_CHECKSUM_EN to build the per-frame checksum; otherwise frame_sum is 0.
module axis_frame_sink
    import axis_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int HEIGHT = 20,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [PIX_W-1:0]  s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    input  logic              enable,
    input  logic              clear_errors,
    output logic [XW-1:0]     pix_x,
    output logic [YW-1:0]     pix_y,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_count,
    output logic [PIX_W-1:0]  frame_sum,
    output logic              err_early_last,
    output logic              err_missing_last
);

    sink_state_t       state_q, state_d;
    logic              tready_q, tready_d;
    logic              frame_done_q, frame_done_d;
    logic [FCNT_W-1:0] frame_count_q, frame_count_d;
    logic              err_early_q, err_early_d;
    logic              err_missing_q, err_missing_d;

    logic beat, at_last, final_beat, early_beat;

    assign beat       = s_axis_tvalid && tready_q;
    assign final_beat = beat && at_last;
    // tlast anywhere but the final pixel resynchronises the raster to (0,0).
    assign early_beat = beat && s_axis_tlast && !at_last;

    raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_raster (
        .aclk    (aclk),
        .aresetn (aresetn),
        .advance (beat && !early_beat),
        .restart (early_beat),
        .x       (pix_x),
        .y       (pix_y),
        .at_last (at_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RECV;
            // enable is ignored mid-frame: the frame in flight always completes.
            RECV:    if (final_beat) state_d = DONE;
            DONE:    state_d = enable ? RECV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // tready is registered, so it is the look-ahead of the next state.
        tready_d      = (state_d == RECV);
        frame_done_d  = final_beat;
        frame_count_d = final_beat ? frame_count_q + 1'b1 : frame_count_q;
        // A new error in the same cycle as clear_errors wins.
        err_early_d   = (err_early_q && !clear_errors) || early_beat;
        err_missing_d = (err_missing_q && !clear_errors) || (final_beat && !s_axis_tlast);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= IDLE;
            tready_q      <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tready_q      <= tready_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
        end
    end

`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
    logic [PIX_W-1:0] acc_q, acc_d;
    logic [PIX_W-1:0] sum_q, sum_d;

    always_comb begin
        acc_d = acc_q;
        sum_d = sum_q;
        if (final_beat) begin
            sum_d = acc_q + s_axis_tdata;
            acc_d = '0;
        end else if (early_beat) begin
            acc_d = '0;
        end else if (beat) begin
            acc_d = acc_q + s_axis_tdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            acc_q <= acc_d;
            sum_q <= sum_d;
        end
    end

    assign frame_sum = sum_q;
`else
    logic unused_tdata;
    assign unused_tdata = ^s_axis_tdata;
    assign frame_sum    = '0;
`endif

    assign s_axis_tready    = tready_q;
    assign frame_done       = frame_done_q;
    assign frame_count      = frame_count_q;
    assign err_early_last   = err_early_q;
    assign err_missing_last = err_missing_q;

endmodule

// File: tb/tb_axis_frame_sink.sv
// Directed bench for axis_frame_sink with a 4x2 raster.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_axis_frame_sink;

`ifdef AXIS_FRAME_SINK_CHECKSUM_EN
    localparam logic [31:0] SUM_1_8 = 32'h0000_0024;
    localparam logic [31:0] SUM_FF  = 32'hFFFF_FFF8;
`else
    localparam logic [31:0] SUM_1_8 = 32'h0;
    localparam logic [31:0] SUM_FF  = 32'h0;
`endif

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic        enable = 1'b0;
    logic        clear_errors = 1'b0;
    logic [1:0]  pix_x;
    logic [0:0]  pix_y;
    logic        frame_done;
    logic [15:0] frame_count;
    logic [31:0] frame_sum;
    logic        err_early_last;
    logic        err_missing_last;

    int total = 0;
    int passed = 0;
    int done_pulses = 0;

    axis_frame_sink #(.WIDTH(4), .HEIGHT(2)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .enable           (enable),
        .clear_errors     (clear_errors),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .frame_done       (frame_done),
        .frame_count      (frame_count),
        .frame_sum        (frame_sum),
        .err_early_last   (err_early_last),
        .err_missing_last (err_missing_last)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) if (frame_done === 1'b1) done_pulses++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic do_reset();
        aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        enable = 1'b0; clear_errors = 1'b0; s_axis_tdata = '0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    // One beat: present data at a negedge, wait (bounded) for tready, complete at the posedge.
    task automatic send(input logic [31:0] d, input logic l);
        int waits = 0;
        @(negedge aclk);
        s_axis_tdata = d; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        while (s_axis_tready !== 1'b1 && waits < 20) begin
            @(negedge aclk);
            waits++;
        end
        if (s_axis_tready !== 1'b1) begin
            total++;
            $display("FAIL send_timeout: tready=%b after %0d cycles, required 1", s_axis_tready, waits);
            s_axis_tvalid = 1'b0;
        end else begin
            @(posedge aclk);
            #1;
            s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        end
    endtask

    task automatic start_enabled();
        do_reset();
        @(posedge aclk); #1;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #12;
        total++; if (s_axis_tready !== 1'b0) $display("FAIL rst_tready: got %b required 0", s_axis_tready); else passed++;
        total++; if (frame_done !== 1'b0) $display("FAIL rst_done: got %b required 0", frame_done); else passed++;
        total++; if (frame_count !== 16'd0) $display("FAIL rst_count: got %0d required 0", frame_count); else passed++;
        total++; if (frame_sum !== 32'd0) $display("FAIL rst_sum: got %h required 0", frame_sum); else passed++;
        total++; if ({err_early_last, err_missing_last} !== 2'b00) $display("FAIL rst_errs: got %b required 00", {err_early_last, err_missing_last}); else passed++;
        total++; if ({pix_x, pix_y} !== 3'b000) $display("FAIL rst_pix: got x=%0d y=%0d required 0/0", pix_x, pix_y); else passed++;
    endtask

    task automatic test_basic_frame();
        int p0;
        do_reset();
        @(posedge aclk); #1;
        enable = 1'b1;
        @(negedge aclk);
        total++; if (s_axis_tready !== 1'b0) $display("FAIL en_latency_lo: tready=%b required 0", s_axis_tready); else passed++;
        @(posedge aclk); #1;
        total++; if (s_axis_tready !== 1'b1) $display("FAIL en_latency_hi: tready=%b required 1", s_axis_tready); else passed++;
        p0 = done_pulses;
        for (int i = 1; i <= 8; i++) begin
            send(32'(i), i == 8);
            if (i == 5) begin
                total++; if ({pix_x, pix_y} !== {2'd1, 1'd1}) $display("FAIL basic_pos5: got x=%0d y=%0d required 1/1", pix_x, pix_y); else passed++;
            end
        end
        total++; if (frame_done !== 1'b1) $display("FAIL basic_done: got %b required 1", frame_done); else passed++;
        total++; if (frame_sum !== SUM_1_8) $display("FAIL basic_sum: got %h required %h", frame_sum, SUM_1_8); else passed++;
        total++; if (frame_count !== 16'd1) $display("FAIL basic_count: got %0d required 1", frame_count); else passed++;
        total++; if ({err_early_last, err_missing_last} !== 2'b00) $display("FAIL basic_errs: got %b required 00", {err_early_last, err_missing_last}); else passed++;
        total++; if (s_axis_tready !== 1'b0) $display("FAIL basic_dead_cycle: tready=%b required 0", s_axis_tready); else passed++;
        total++; if ({pix_x, pix_y} !== 3'b000) $display("FAIL basic_pos_wrap: got x=%0d y=%0d required 0/0", pix_x, pix_y); else passed++;
        @(posedge aclk); #1;
        total++; if (frame_done !== 1'b0) $display("FAIL basic_done_pulse: got %b required 0", frame_done); else passed++;
        total++; if (s_axis_tready !== 1'b1) $display("FAIL basic_tready_back: got %b required 1", s_axis_tready); else passed++;
        total++; if (done_pulses - p0 !== 1) $display("FAIL basic_pulses: got %0d required 1", done_pulses - p0); else passed++;
    endtask

    task automatic test_early_last();
        int p0;
        start_enabled();
        p0 = done_pulses;
        for (int i = 1; i <= 5; i++) send(32'(i), i == 5);
        total++; if (err_early_last !== 1'b1) $display("FAIL early_flag: got %b required 1", err_early_last); else passed++;
        total++; if ({pix_x, pix_y} !== 3'b000) $display("FAIL early_restart: got x=%0d y=%0d required 0/0", pix_x, pix_y); else passed++;
        total++; if (frame_count !== 16'd0) $display("FAIL early_count: got %0d required 0", frame_count); else passed++;
        total++; if (done_pulses - p0 !== 0) $display("FAIL early_no_done: got %0d pulses required 0", done_pulses - p0); else passed++;
        total++; if (s_axis_tready !== 1'b1) $display("FAIL early_stay_recv: tready=%b required 1", s_axis_tready); else passed++;
        for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
        total++; if (frame_sum !== SUM_1_8) $display("FAIL early_then_sum: got %h required %h", frame_sum, SUM_1_8); else passed++;
        total++; if (frame_count !== 16'd1) $display("FAIL early_then_count: got %0d required 1", frame_count); else passed++;
        total++; if (err_missing_last !== 1'b0) $display("FAIL early_no_missing: got %b required 0", err_missing_last); else passed++;
    endtask

    task automatic test_missing_last();
        start_enabled();
        for (int i = 1; i <= 8; i++) send(32'(i), 1'b0);
        total++; if (err_missing_last !== 1'b1) $display("FAIL missing_flag: got %b required 1", err_missing_last); else passed++;
        total++; if (frame_done !== 1'b1) $display("FAIL missing_done: got %b required 1", frame_done); else passed++;
        total++; if (frame_count !== 16'd1) $display("FAIL missing_count: got %0d required 1", frame_count); else passed++;
        total++; if (err_early_last !== 1'b0) $display("FAIL missing_no_early: got %b required 0", err_early_last); else passed++;
        @(negedge aclk);
        clear_errors = 1'b1;
        @(posedge aclk); #1;
        clear_errors = 1'b0;
        total++; if (err_missing_last !== 1'b0) $display("FAIL missing_clear: got %b required 0", err_missing_last); else passed++;
    endtask

    task automatic test_gaps();
        start_enabled();
        for (int f = 0; f < 3; f++) begin
            for (int i = 1; i <= 8; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge aclk);
                send(32'hFFFF_FFFF, i == 8);
            end
            total++; if (frame_sum !== SUM_FF) $display("FAIL gaps_sum%0d: got %h required %h", f, frame_sum, SUM_FF); else passed++;
        end
        total++; if (frame_count !== 16'd3) $display("FAIL gaps_count: got %0d required 3", frame_count); else passed++;
        total++; if ({pix_x, pix_y} !== 3'b000) $display("FAIL gaps_pos: got x=%0d y=%0d required 0/0", pix_x, pix_y); else passed++;
    endtask

    task automatic test_enable_drop();
        start_enabled();
        for (int i = 1; i <= 8; i++) begin
            send(32'(i), i == 8);
            if (i == 3) enable = 1'b0;
        end
        total++; if (frame_count !== 16'd1) $display("FAIL drop_count: got %0d required 1", frame_count); else passed++;
        total++; if (frame_done !== 1'b1) $display("FAIL drop_done: got %b required 1", frame_done); else passed++;
        @(negedge aclk);
        s_axis_tdata = 32'd99; s_axis_tvalid = 1'b1;
        repeat (4) @(posedge aclk);
        #1;
        total++; if (s_axis_tready !== 1'b0) $display("FAIL drop_idle_tready: got %b required 0", s_axis_tready); else passed++;
        total++; if ({pix_x, pix_y} !== 3'b000) $display("FAIL drop_no_beats: got x=%0d y=%0d required 0/0", pix_x, pix_y); else passed++;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        start_enabled();
        for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
        for (int i = 1; i <= 6; i++) send(32'(i), 1'b0);
        total++; if ({pix_x, pix_y} !== {2'd2, 1'd1}) $display("FAIL midrst_pos6: got x=%0d y=%0d required 2/1", pix_x, pix_y); else passed++;
        #2;
        aresetn = 1'b0;
        #1;
        total++; if (frame_count !== 16'd0) $display("FAIL midrst_count: got %0d required 0", frame_count); else passed++;
        total++; if (frame_sum !== 32'd0) $display("FAIL midrst_sum: got %h required 0", frame_sum); else passed++;
        total++; if ({pix_x, pix_y} !== 3'b000) $display("FAIL midrst_pos: got x=%0d y=%0d required 0/0", pix_x, pix_y); else passed++;
        total++; if (s_axis_tready !== 1'b0) $display("FAIL midrst_tready: got %b required 0", s_axis_tready); else passed++;
        start_enabled();
        for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
        total++; if (frame_count !== 16'd1) $display("FAIL midrst_fresh_count: got %0d required 1", frame_count); else passed++;
        total++; if (frame_sum !== SUM_1_8) $display("FAIL midrst_fresh_sum: got %h required %h", frame_sum, SUM_1_8); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_early_last();
        test_missing_last();
        test_gaps();
        test_enable_drop();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axis_frame_sink.md
# axis_frame_sink

AXI4-Stream slave that receives fixed-size raster frames of 32-bit pixels from the pixel generator's master port and checks them. It tracks the pixel position, checks that `tlast` falls exactly on the final pixel, and counts completed frames. Optionally it also produces a per-frame checksum. It is the receiving end of the pixel stream and is used in demos and benches as a frame consumer and checker.

## Interface
- `WIDTH`, 20, pixels per line (≥2)
- `HEIGHT`, 20, lines per frame (≥1)
- `aclk` input 1: clock, all logic on rising edge
- `aresetn` input 1: reset, asynchronous, active-low
- `s_axis_tdata` input 32: pixel data
- `s_axis_tvalid` input 1: beat valid
- `s_axis_tready` output 1: sink ready, registered
- `s_axis_tlast` input 1: final pixel of frame
- `enable` input 1: allow reception of frames
- `clear_errors` input 1: clears both sticky error flags
- `pix_x` output $clog2(WIDTH): column of the next expected pixel
- `pix_y` output $clog2(HEIGHT): row of the next expected pixel
- `frame_done` output 1: one-cycle pulse per completed frame
- `frame_count` output 16: completed frames, wraps at 2^16
- `frame_sum` output 32: checksum of the last completed frame
- `err_early_last` output 1: sticky; `tlast` arrived before the final pixel
- `err_missing_last` output 1: sticky; final pixel arrived without `tlast`

## Operation
- Beat: `s_axis_tvalid && s_axis_tready` sampled at the `aclk` edge.
- State machine:
  - IDLE: `s_axis_tready`=0. Goes to RECV when `enable`=1.
  - RECV: `s_axis_tready`=1. Advances the position on every beat.
  - DONE: lasts one cycle. `s_axis_tready`=0, `frame_done`=1. Goes to RECV if `enable`=1, else IDLE.
- Position counting: x increments per beat. At x=WIDTH-1, x wraps to 0 and y increments. The final pixel is x=WIDTH-1, y=HEIGHT-1; after it, x and y are both 0.
- Final-pixel beat, normal case: enter DONE, increment `frame_count`, latch the accumulator into `frame_sum`, clear the accumulator.
- Final-pixel beat with `tlast`=0: set `err_missing_last` and complete the frame normally as above.
- `tlast`=1 on any other beat:
  - set `err_early_last`;
  - reset x, y and the accumulator to 0;
  - do not pulse `frame_done`, do not change `frame_count` or `frame_sum`;
  - stay in RECV, so the next beat is pixel (0,0).
- `enable` deasserted mid-frame: the current frame still completes, then DONE→IDLE.
- `clear_errors` in the same cycle as a new error: the set wins.
- Checksum: 32-bit wrapping sum of `tdata` over all beats of the frame.

## Timing
- All outputs are registered.
- Reset values: `s_axis_tready`=0, `frame_done`=0, `frame_count`=0, `frame_sum`=0, both error flags 0, `pix_x`=0, `pix_y`=0, state IDLE.
- `enable` rises at edge N: `s_axis_tready`=1 after edge N+1 (IDLE→RECV takes one cycle).
- Final beat at edge N: `frame_done`=1 and the new `frame_sum`/`frame_count` visible after edge N. `s_axis_tready`=0 for that one cycle, then 1 again after edge N+1 if `enable` is still 1.
- `frame_sum` holds its value until the next `frame_done`.
- Error flags are visible the cycle after the offending beat.
- Asserting `aresetn` low mid-frame clears everything immediately and asynchronously; the partial frame is discarded.
- Throughput: WIDTH*HEIGHT beats per frame, plus one dead cycle per frame.

## Configuration
- `AXIS_FRAME_SINK_CHECKSUM_EN` defined: the accumulator and `frame_sum` operate as specified above.
- Not defined: the accumulator is not built, `frame_sum` is tied to 0, and all other behaviour is unchanged.

## Structure
- Shared package `axis_pkg` holds:
  - the state typedef `sink_state_t` {IDLE, RECV, DONE};
  - the 32-bit pixel data width constant;
  - the 16-bit frame-count width constant.
- Sub-module `raster_counter`, parameterised by WIDTH and HEIGHT:
  - inputs: `advance`, `restart`;
  - outputs: x, y, and `at_last` (combinational, true at (WIDTH-1, HEIGHT-1)).
- The FSM, error flags and checksum live in the top module.

## Test plan
All scenarios use WIDTH=4, HEIGHT=2.
- Reset, then `enable`=1; stream data 1..8 continuously with `tlast` on beat 8 → one `frame_done` pulse, `frame_sum`=0x24, `frame_count`=1, both error flags 0, `tready` low for exactly 1 cycle.
- `tlast` on beat 5 (data 1..5), then a clean frame 1..8 → `err_early_last`=1 the cycle after beat 5, no `frame_done` for beats 1–5, then `frame_sum`=0x24 and `frame_count`=1.
- Frame 1..8 with `tlast`=0 throughout → `err_missing_last`=1, `frame_done` pulses, `frame_count`=1; `clear_errors` then returns the flag to 0.
- Random `tvalid` gaps over 3 frames of value 0xFFFFFFFF → each `frame_sum`=0xFFFFFFF8, `frame_count`=3, `pix_x`/`pix_y` back at 0/0.
- `enable` dropped after beat 3 → frame completes at beat 8, then IDLE with `tready`=0; no further beats accepted.
- `aresetn` low after beat 6 → all outputs at reset values at once; a fresh 8-beat frame then gives `frame_count`=1.
